// File: rtl/microstate_sequencer.sv
// Microprogram sequencer: holds the control-ROM address and selects the next one from
// the ROM word's mode field, dispatch target, branch condition and memory handshake.
module microstate_sequencer #(
    parameter int unsigned STATE_W     = 7,
    parameter int unsigned RESET_STATE = 0,
    parameter int unsigned FETCH_STATE = 1,
    parameter int unsigned FAULT_STATE = 127,
    parameter int unsigned MOC_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 6
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [STATE_W-1:0] Decoded_State,
    input  logic [2:0]         N_Sel,
    input  logic [STATE_W-1:0] CR_Addr,
    input  logic               Inv,
    input  logic               Cond,
    input  logic               MOC,
    input  logic [CNT_W-1:0]   Cnt_Load,
    input  logic               Stall,
    output logic [STATE_W-1:0] State,
    output logic               Dispatch,
    output logic               Repeating,
    output logic               Mem_Fault
);

    // wait_cnt never exceeds MOC_TIMEOUT-1, so clog2 bits are enough.
    localparam int unsigned WAIT_W = (MOC_TIMEOUT > 2) ? $clog2(MOC_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ModeDispatch = 3'd0,
        ModeInc      = 3'd1,
        ModeJump     = 3'd2,
        ModeBranch   = 3'd3,
        ModeMemWait  = 3'd4,
        ModeRepeat   = 3'd5,
        ModeFetch    = 3'd6,
        ModeIllegal  = 3'd7
    } mode_e;

    logic [STATE_W-1:0] r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_rep_cnt;
    logic               r_repeating;
    logic               r_mem_fault;

    mode_e              w_mode;
    logic [STATE_W-1:0] w_state_inc;
    logic [STATE_W-1:0] w_state_d;
    logic [WAIT_W-1:0]  w_wait_d;
    logic [CNT_W-1:0]   w_rep_d;
    logic               w_repeating_d;
    logic               w_fault_d;

    assign w_mode      = mode_e'(N_Sel);
    assign w_state_inc = r_state + STATE_W'(1);

    always_comb begin
        w_state_d     = r_state;
        w_wait_d      = '0;
        w_rep_d       = '0;
        w_repeating_d = 1'b0;
        w_fault_d     = r_mem_fault;
        if (Stall) begin
            w_wait_d      = r_wait_cnt;
            w_rep_d       = r_rep_cnt;
            w_repeating_d = r_repeating;
        end else begin
            unique case (w_mode)
                ModeDispatch: w_state_d = Decoded_State;
                ModeInc:      w_state_d = w_state_inc;
                ModeJump:     w_state_d = CR_Addr;
                ModeBranch:   w_state_d = (Cond ^ Inv) ? CR_Addr : w_state_inc;
                ModeMemWait: begin
                    // MOC arriving on the timeout cycle takes precedence over the fault.
                    if (MOC) begin
                        w_state_d = w_state_inc;
                    end else if (r_wait_cnt == WAIT_W'(MOC_TIMEOUT - 1)) begin
                        w_state_d = STATE_W'(FAULT_STATE);
                        w_fault_d = 1'b1;
                    end else begin
                        w_wait_d = r_wait_cnt + WAIT_W'(1);
                    end
                end
                ModeRepeat: begin
                    if (r_repeating) begin
                        if (r_rep_cnt == CNT_W'(1)) begin
                            w_state_d = w_state_inc;
                        end else begin
                            w_rep_d       = r_rep_cnt - CNT_W'(1);
                            w_repeating_d = 1'b1;
                        end
                    end else if (Cnt_Load <= CNT_W'(1)) begin
                        w_state_d = w_state_inc;
                    end else begin
                        w_rep_d       = Cnt_Load - CNT_W'(1);
                        w_repeating_d = 1'b1;
                    end
                end
                ModeFetch:    w_state_d = STATE_W'(FETCH_STATE);
                ModeIllegal:  w_state_d = STATE_W'(FAULT_STATE);
                default:      w_state_d = STATE_W'(FAULT_STATE);
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= STATE_W'(RESET_STATE);
            r_wait_cnt  <= '0;
            r_rep_cnt   <= '0;
            r_repeating <= 1'b0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_wait_cnt  <= w_wait_d;
            r_rep_cnt   <= w_rep_d;
            r_repeating <= w_repeating_d;
            r_mem_fault <= w_fault_d;
        end
    end

    assign State     = r_state;
    assign Dispatch  = (N_Sel == 3'd0) & ~Stall;
    assign Repeating = r_repeating;
    assign Mem_Fault = r_mem_fault;

endmodule

// File: tb/tb_microstate_sequencer.sv
// Directed-vector bench for microstate_sequencer with hand-computed expected states.
module tb_microstate_sequencer;

    logic       Clk;
    logic       Reset_n;
    logic [6:0] Decoded_State;
    logic [2:0] N_Sel;
    logic [6:0] CR_Addr;
    logic       Inv;
    logic       Cond;
    logic       MOC;
    logic [5:0] Cnt_Load;
    logic       Stall;
    logic [6:0] State;
    logic       Dispatch;
    logic       Repeating;
    logic       Mem_Fault;

    int n_vec  = 0;
    int n_miss = 0;

    microstate_sequencer dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Decoded_State (Decoded_State),
        .N_Sel         (N_Sel),
        .CR_Addr       (CR_Addr),
        .Inv           (Inv),
        .Cond          (Cond),
        .MOC           (MOC),
        .Cnt_Load      (Cnt_Load),
        .Stall         (Stall),
        .State         (State),
        .Dispatch      (Dispatch),
        .Repeating     (Repeating),
        .Mem_Fault     (Mem_Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic jump_to(input logic [6:0] addr);
        N_Sel   = 3'd2;
        CR_Addr = addr;
        step();
    endtask

    initial begin
        int res;
        bit done;
        Reset_n       = 1'b1;
        Decoded_State = 7'd0;
        N_Sel         = 3'd1;
        CR_Addr       = 7'd0;
        Inv           = 1'b0;
        Cond          = 1'b0;
        MOC           = 1'b0;
        Cnt_Load      = 6'd0;
        Stall         = 1'b0;

        // Asynchronous reset mid-cycle
        #3 Reset_n = 1'b0;
        #1;
        check_eq("reset_state", State, 0);
        check_eq("reset_fault", Mem_Fault, 0);
        check_eq("reset_rep", Repeating, 0);
        step();
        @(negedge Clk) Reset_n = 1'b1;
        step();
        check_eq("fetch_inc1", State, 1);
        step();
        check_eq("fetch_inc2", State, 2);
        N_Sel = 3'd0;
        Decoded_State = 7'd6;
        #1 check_eq("dispatch_hi", Dispatch, 1);
        step();
        check_eq("dispatch_state", State, 6);

        // Branch
        jump_to(7'd11);
        check_eq("jump11", State, 11);
        N_Sel = 3'd3; CR_Addr = 7'd40; Inv = 1'b0; Cond = 1'b1;
        #1 check_eq("branch_no_dispatch", Dispatch, 0);
        step();
        check_eq("branch_taken", State, 40);
        jump_to(7'd11);
        N_Sel = 3'd3; CR_Addr = 7'd40; Cond = 1'b0;
        step();
        check_eq("branch_not_taken", State, 12);
        jump_to(7'd11);
        N_Sel = 3'd3; CR_Addr = 7'd40; Inv = 1'b1; Cond = 1'b0;
        step();
        check_eq("branch_inv", State, 40);
        Inv = 1'b0;

        // Illegal mode without a fault, then wrap
        jump_to(7'd5);
        N_Sel = 3'd7;
        step();
        check_eq("illegal_state", State, 127);
        check_eq("illegal_nofault", Mem_Fault, 0);
        N_Sel = 3'd1;
        step();
        check_eq("wrap", State, 0);
        N_Sel = 3'd6;
        step();
        check_eq("fetch_mode", State, 1);

        // Memory wait: 3 low then high
        jump_to(7'd13);
        N_Sel = 3'd4; MOC = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("memwait_hold", State, 13);
        end
        MOC = 1'b1;
        step();
        check_eq("memwait_done", State, 14);

        // MOC rises on the 16th cycle: no fault
        jump_to(7'd13);
        N_Sel = 3'd4; MOC = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check_eq("moc16_hold", State, 13);
        MOC = 1'b1;
        step();
        check_eq("moc16_state", State, 14);
        check_eq("moc16_nofault", Mem_Fault, 0);

        // Stalled cycles do not count toward the timeout
        jump_to(7'd13);
        N_Sel = 3'd4; MOC = 1'b0;
        for (int i = 0; i < 10; i++) step();
        Stall = 1'b1;
        for (int i = 0; i < 8; i++) step();
        Stall = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_eq("timeout_stall_hold", State, 13);
        check_eq("timeout_stall_nofault", Mem_Fault, 0);
        MOC = 1'b1;
        step();
        check_eq("timeout_stall_exit", State, 14);

        // Timeout after 16 low cycles
        jump_to(7'd13);
        N_Sel = 3'd4; MOC = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check_eq("timeout_pre_state", State, 13);
        check_eq("timeout_pre_fault", Mem_Fault, 0);
        step();
        check_eq("timeout_state", State, 127);
        check_eq("timeout_fault", Mem_Fault, 1);
        MOC = 1'b1;
        jump_to(7'd20);
        N_Sel = 3'd7;
        step();
        check_eq("fault_sticky_state", State, 127);
        check_eq("fault_sticky", Mem_Fault, 1);

        // Repeat 32; Cnt_Load changed after the first cycle must be ignored
        jump_to(7'd49);
        N_Sel = 3'd5; Cnt_Load = 6'd32;
        for (int c = 1; c <= 32; c++) begin
            check_eq("rep32_state", State, 49);
            check_eq("rep32_flag", Repeating, (c >= 2) ? 1 : 0);
            step();
            Cnt_Load = 6'd3;
        end
        check_eq("rep32_exit", State, 50);
        check_eq("rep32_flag_clr", Repeating, 0);

        jump_to(7'd49);
        N_Sel = 3'd5; Cnt_Load = 6'd0;
        step();
        check_eq("rep0", State, 50);
        check_eq("rep0_flag", Repeating, 0);
        jump_to(7'd49);
        N_Sel = 3'd5; Cnt_Load = 6'd1;
        step();
        check_eq("rep1", State, 50);

        // Repeat 32 with a 5-cycle stall: 37 cycles resident
        jump_to(7'd49);
        N_Sel = 3'd5; Cnt_Load = 6'd32;
        res = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            Stall = (c >= 10 && c < 15);
            if (State == 7'd49) begin
                res++;
                step();
            end else begin
                done = 1'b1;
            end
        end
        Stall = 1'b0;
        check_eq("rep_stall_res", res, 37);
        check_eq("rep_stall_exit", State, 50);

        // Stall during dispatch
        N_Sel = 3'd0; Decoded_State = 7'd6; Stall = 1'b1;
        #1 check_eq("stall_dispatch_lo", Dispatch, 0);
        step();
        check_eq("stall_hold", State, 50);
        Stall = 1'b0;
        #1 check_eq("unstall_dispatch_hi", Dispatch, 1);
        step();
        check_eq("unstall_state", State, 6);

        // Reset mid-repeat abandons it and clears the fault
        jump_to(7'd49);
        N_Sel = 3'd5; Cnt_Load = 6'd10;
        step();
        step();
        #2 Reset_n = 1'b0;
        #1;
        check_eq("rst_mid_state", State, 0);
        check_eq("rst_mid_fault", Mem_Fault, 0);
        check_eq("rst_mid_rep", Repeating, 0);
        N_Sel = 3'd1;
        @(negedge Clk) Reset_n = 1'b1;
        step();
        check_eq("rst_release", State, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
